// File: rtl/otter_lsu_pkg.sv
// Shared definitions for the OTTER load/store unit.
// Contents: the LSU state enum, the memory size codes used on the data port,
// and the default first byte address of the memory-mapped IO region.
package otter_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  typedef logic [1:0] mem_size_t;

  localparam mem_size_t SIZE_BYTE = 2'd0;
  localparam mem_size_t SIZE_HALF = 2'd1;
  localparam mem_size_t SIZE_WORD = 2'd2;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0001_0000;

endpackage

// File: rtl/otter_lsu_align_check.sv
// Combinational legality check for a data access.
// Ports:
//   size       in  2  access size code (byte/half/word, 3 is illegal)
//   addr_lo    in  2  low two bits of the byte address
//   misaligned out 1  access cannot be performed by the memory
module otter_lsu_align_check
  import otter_lsu_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic       misaligned
);

  // The memory handles a halfword at offset 1 (it stays inside the word),
  // so only a halfword at offset 3 straddles a word boundary.
  always_comb begin
    misaligned = 1'b0;
    case (size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = (addr_lo == 2'd3);
      SIZE_WORD: misaligned = (addr_lo != 2'd0);
      default:   misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/otter_load_store_unit.sv
// Pipeline-side initiator for the data port (port 2) of the OTTER memory.
// Takes one request from the MEM stage, drives the memory strobes for exactly
// one cycle (the memory acts on the negedge inside it), then returns the
// captured read data with error and IO flags.
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   REQ_VALID/REQ_READY       request handshake
//   REQ_WE/ADDR/WDATA/SIZE/SIGN  request fields (SIGN=1 means unsigned load)
//   RESP_VALID/RESP_READY     response handshake
//   RESP_RDATA/ERR/IO         load result, misalignment flag, IO-region flag
//   MEM_RDEN2/WE2/ADDR2/DIN2/SIZE/SIGN  memory port-2 controls
//   MEM_DOUT2                 sized read data or IO buffer from the memory
module otter_load_store_unit
  import otter_lsu_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_SIGN,
  output logic        RESP_VALID,
  input  logic        RESP_READY,
  output logic [31:0] RESP_RDATA,
  output logic        RESP_ERR,
  output logic        RESP_IO,
  output logic        MEM_RDEN2,
  output logic        MEM_WE2,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2
);

  lsu_state_t state;
  lsu_state_t next_state;
  logic       req_we;
  logic       misaligned;

  otter_lsu_align_check u_align (
    .size       (REQ_SIZE),
    .addr_lo    (REQ_ADDR[1:0]),
    .misaligned (misaligned)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: illegal requests skip the memory access entirely.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (REQ_VALID) next_state = misaligned ? RESP : ACCESS;
      ACCESS:  next_state = RESP;
      RESP:    if (RESP_READY) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake and strobe outputs are decoded from registered state only,
  // so the strobes cannot glitch while the memory samples them.
  always_comb begin
    REQ_READY  = (state == IDLE);
    RESP_VALID = (state == RESP);
    MEM_RDEN2  = (state == ACCESS) && !req_we;
    MEM_WE2    = (state == ACCESS) &&  req_we;
  end

  // The MEM_* address/data/size/sign registers double as the request
  // register. They load only for legal requests, so after an access they
  // keep holding the last accessed location and the memory's combinational
  // sizing stays stable.
  always_ff @(posedge CLK) begin
    if (RST) begin
      req_we     <= 1'b0;
      MEM_ADDR2  <= '0;
      MEM_DIN2   <= '0;
      MEM_SIZE   <= '0;
      MEM_SIGN   <= 1'b0;
      RESP_RDATA <= '0;
      RESP_ERR   <= 1'b0;
      RESP_IO    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (REQ_VALID) begin
            if (misaligned) begin
              RESP_ERR   <= 1'b1;
              RESP_RDATA <= '0;
              RESP_IO    <= (REQ_ADDR >= MMIO_BASE);
            end else begin
              req_we    <= REQ_WE;
              MEM_ADDR2 <= REQ_ADDR;
              MEM_DIN2  <= REQ_WDATA;
              MEM_SIZE  <= REQ_SIZE;
              MEM_SIGN  <= REQ_SIGN;
            end
          end
        end
        ACCESS: begin
          RESP_ERR   <= 1'b0;
          RESP_RDATA <= req_we ? 32'd0 : MEM_DOUT2;
          RESP_IO    <= (MEM_ADDR2 >= MMIO_BASE);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_load_store_unit.sv
// Testbench for otter_load_store_unit.
// A behavioural memory sits on the port-2 pins; a separate byte-level
// reference memory plus per-cycle expectations describe what the LSU must do.
module tb_otter_load_store_unit;

  localparam logic [31:0] MMIO_BASE = 32'h0001_0000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic [1:0]  REQ_SIZE;
  logic        REQ_SIGN;
  logic        RESP_VALID;
  logic        RESP_READY;
  logic [31:0] RESP_RDATA;
  logic        RESP_ERR;
  logic        RESP_IO;
  logic        MEM_RDEN2;
  logic        MEM_WE2;
  logic [31:0] MEM_ADDR2;
  logic [31:0] MEM_DIN2;
  logic [1:0]  MEM_SIZE;
  logic        MEM_SIGN;
  logic [31:0] MEM_DOUT2 = 32'd0;

  int checks = 0;
  int errors = 0;

  otter_load_store_unit #(.MMIO_BASE(MMIO_BASE)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ_VALID  (REQ_VALID),
    .REQ_READY  (REQ_READY),
    .REQ_WE     (REQ_WE),
    .REQ_ADDR   (REQ_ADDR),
    .REQ_WDATA  (REQ_WDATA),
    .REQ_SIZE   (REQ_SIZE),
    .REQ_SIGN   (REQ_SIGN),
    .RESP_VALID (RESP_VALID),
    .RESP_READY (RESP_READY),
    .RESP_RDATA (RESP_RDATA),
    .RESP_ERR   (RESP_ERR),
    .RESP_IO    (RESP_IO),
    .MEM_RDEN2  (MEM_RDEN2),
    .MEM_WE2    (MEM_WE2),
    .MEM_ADDR2  (MEM_ADDR2),
    .MEM_DIN2   (MEM_DIN2),
    .MEM_SIZE   (MEM_SIZE),
    .MEM_SIGN   (MEM_SIGN),
    .MEM_DOUT2  (MEM_DOUT2)
  );

  always #5 CLK = ~CLK;

  // Memory contents as seen on the pins, and the reference contents.
  logic [7:0]  env_mem [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] io_in = 32'd0;

  function automatic logic [7:0] env_byte(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic int size_bytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  // Size and sign-extend a little-endian raw value (sign=1 means unsigned).
  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                         input logic uns);
    case (size)
      2'd0:    return uns ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'd1:    return uns ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // Behavioural memory: acts on the negedge inside the strobe cycle.
  always @(negedge CLK) begin
    if (MEM_WE2 && MEM_ADDR2 < MMIO_BASE)
      for (int b = 0; b < size_bytes(MEM_SIZE); b++)
        env_mem[MEM_ADDR2 + b] = MEM_DIN2[8*b +: 8];
    if (MEM_RDEN2) begin
      if (MEM_ADDR2 >= MMIO_BASE) MEM_DOUT2 = io_in;
      else MEM_DOUT2 = extend({env_byte(MEM_ADDR2 + 3), env_byte(MEM_ADDR2 + 2),
                               env_byte(MEM_ADDR2 + 1), env_byte(MEM_ADDR2)},
                              MEM_SIZE, MEM_SIGN);
    end
  end

  // Per-cycle expectations.
  logic        checking = 1'b0;
  logic        exp_busy, exp_valid, exp_rd, exp_we;
  logic [31:0] exp_rdata, exp_addr, exp_din;
  logic        exp_err, exp_io, exp_sign;
  logic [1:0]  exp_size;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every negedge the DUT outputs must match the model.
  always @(negedge CLK) begin
    if (checking) begin
      check("req_ready", 32'(REQ_READY), 32'(!exp_busy));
      check("resp_valid", 32'(RESP_VALID), 32'(exp_valid));
      check("mem_rden2", 32'(MEM_RDEN2), 32'(exp_rd));
      check("mem_we2", 32'(MEM_WE2), 32'(exp_we));
      check("mem_addr2", MEM_ADDR2, exp_addr);
      check("mem_size", 32'(MEM_SIZE), 32'(exp_size));
      check("mem_sign", 32'(MEM_SIGN), 32'(exp_sign));
      if (exp_we) check("mem_din2", MEM_DIN2, exp_din);
      if (exp_valid) begin
        check("resp_rdata", RESP_RDATA, exp_rdata);
        check("resp_err", 32'(RESP_ERR), 32'(exp_err));
        check("resp_io", 32'(RESP_IO), 32'(exp_io));
      end
    end
  end

  task automatic expect_reset_state();
    exp_busy = 1'b0; exp_valid = 1'b0; exp_rd = 1'b0; exp_we = 1'b0;
    exp_addr = '0; exp_size = '0; exp_sign = 1'b0; exp_din = '0;
    exp_rdata = '0; exp_err = 1'b0; exp_io = 1'b0;
  endtask

  // Issue one request, hold RESP_READY low for 'hold' cycles of RESP
  // (optionally poking REQ_VALID meanwhile) and return the response seen.
  task automatic apply_stimulus(input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [1:0] size,
                                input logic uns, input int hold, input logic poke,
                                output logic [31:0] got_rdata, output logic got_err,
                                output logic got_io);
    logic        legal;
    logic [31:0] rdata;
    legal = !(size == 2'd3 || (size == 2'd1 && addr[1:0] == 2'd3) ||
              (size == 2'd2 && addr[1:0] != 2'd0));
    rdata = 32'd0;
    if (legal && !we)
      rdata = (addr >= MMIO_BASE) ? io_in :
              extend({ref_byte(addr + 3), ref_byte(addr + 2), ref_byte(addr + 1),
                      ref_byte(addr)}, size, uns);
    if (legal && we && addr < MMIO_BASE)
      for (int b = 0; b < size_bytes(size); b++) ref_mem[addr + b] = wdata[8*b +: 8];

    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WE = we; REQ_ADDR = addr; REQ_WDATA = wdata;
    REQ_SIZE = size; REQ_SIGN = uns;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    exp_busy = 1'b1;
    if (legal) begin
      exp_rd = !we; exp_we = we; exp_addr = addr; exp_size = size;
      exp_sign = uns; exp_din = wdata;
      @(posedge CLK); #1;
      exp_rd = 1'b0; exp_we = 1'b0;
    end
    exp_valid = 1'b1; exp_rdata = rdata; exp_err = !legal;
    exp_io = (addr >= MMIO_BASE);
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        REQ_VALID = 1'b1; REQ_ADDR = 32'h0000_0300; REQ_WE = 1'b1;
      end
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    REQ_VALID = 1'b0;
    got_rdata = RESP_RDATA; got_err = RESP_ERR; got_io = RESP_IO;
    RESP_READY = 1'b1;
    @(posedge CLK); #1;
    RESP_READY = 1'b0;
    exp_valid = 1'b0; exp_busy = 1'b0;
  endtask

  task automatic check_output(input string name, input logic [31:0] got_rdata,
                              input logic got_err, input logic [31:0] want_rdata,
                              input logic want_err);
    check({name, "_rdata"}, got_rdata, want_rdata);
    check({name, "_err"}, 32'(got_err), 32'(want_err));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er, io;
    RST = 1'b1; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0;
    REQ_SIZE = '0; REQ_SIGN = 1'b0; RESP_READY = 1'b0;
    expect_reset_state();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    checking = 1'b1;
    @(negedge CLK);
    check("reset_rdata", RESP_RDATA, 32'd0);
    check("reset_err", 32'(RESP_ERR), 32'd0);
    check("reset_io", 32'(RESP_IO), 32'd0);
    check("reset_din", MEM_DIN2, 32'd0);

    // Word store then load.
    apply_stimulus(1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0, 0, 1'b0, rd, er, io);
    check_output("st_word", rd, er, 32'd0, 1'b0);
    apply_stimulus(1'b0, 32'h100, 32'd0, 2'd2, 1'b0, 0, 1'b0, rd, er, io);
    check_output("ld_word", rd, er, 32'hDEADBEEF, 1'b0);

    // Signed / unsigned byte and half at offset 1.
    apply_stimulus(1'b1, 32'h104, 32'h80FF7F01, 2'd2, 1'b0, 0, 1'b0, rd, er, io);
    apply_stimulus(1'b0, 32'h107, 32'd0, 2'd0, 1'b0, 0, 1'b0, rd, er, io);
    check_output("ld_byte_s", rd, er, 32'hFFFFFF80, 1'b0);
    apply_stimulus(1'b0, 32'h107, 32'd0, 2'd0, 1'b1, 0, 1'b0, rd, er, io);
    check_output("ld_byte_u", rd, er, 32'h00000080, 1'b0);
    apply_stimulus(1'b0, 32'h105, 32'd0, 2'd1, 1'b0, 1, 1'b0, rd, er, io);
    check_output("ld_half_off1", rd, er, 32'hFFFFFF7F, 1'b0);

    // Misaligned and illegal-size requests.
    apply_stimulus(1'b0, 32'h102, 32'd0, 2'd2, 1'b0, 0, 1'b0, rd, er, io);
    check_output("mis_word", rd, er, 32'd0, 1'b1);
    apply_stimulus(1'b0, 32'h103, 32'd0, 2'd1, 1'b0, 2, 1'b0, rd, er, io);
    check_output("mis_half", rd, er, 32'd0, 1'b1);
    apply_stimulus(1'b1, 32'h100, 32'h11111111, 2'd3, 1'b0, 0, 1'b0, rd, er, io);
    check_output("bad_size", rd, er, 32'd0, 1'b1);

    // Backpressure with requests offered while busy.
    apply_stimulus(1'b0, 32'h100, 32'd0, 2'd2, 1'b0, 5, 1'b1, rd, er, io);
    check_output("backpressure", rd, er, 32'hDEADBEEF, 1'b0);

    // IO load and store.
    io_in = 32'h12345678;
    apply_stimulus(1'b0, 32'h1100_0000, 32'd0, 2'd2, 1'b0, 0, 1'b0, rd, er, io);
    check_output("io_load", rd, er, 32'h12345678, 1'b0);
    check("io_load_flag", 32'(io), 32'd1);
    apply_stimulus(1'b1, 32'h1100_0004, 32'hA5A5A5A5, 2'd2, 1'b0, 0, 1'b0, rd, er, io);
    check("io_store_flag", 32'(io), 32'd1);

    // Reset during the ACCESS cycle of a store.
    for (int b = 0; b < 4; b++) ref_mem[32'h200 + b] = 8'(32'hCAFEF00D >> (8 * b));
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 32'h200; REQ_WDATA = 32'hCAFEF00D;
    REQ_SIZE = 2'd2; REQ_SIGN = 1'b0;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0; RST = 1'b1;
    exp_busy = 1'b1; exp_we = 1'b1; exp_addr = 32'h200; exp_size = 2'd2;
    exp_sign = 1'b0; exp_din = 32'hCAFEF00D;
    @(posedge CLK); #1;
    RST = 1'b0;
    expect_reset_state();
    @(negedge CLK);
    check("rst_access_rdata", RESP_RDATA, 32'd0);
    check("rst_access_err", 32'(RESP_ERR), 32'd0);
    check("rst_access_din", MEM_DIN2, 32'd0);
    repeat (3) @(posedge CLK);
    apply_stimulus(1'b0, 32'h200, 32'd0, 2'd2, 1'b0, 0, 1'b0, rd, er, io);
    check_output("rst_write_kept", rd, er, 32'hCAFEF00D, 1'b0);

    repeat (2) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
